// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command issuer: op codes, FSM states
// and the operand/op payload carried through the command FIFO.
package alu_pkg;

  localparam logic [3:0] OP_W = 4'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } issuer_state_t;

  // The tag is parameterised per instance, so it is appended beside this struct
  // rather than inside it.
  typedef struct packed {
    logic [3:0]      a;
    logic [3:0]      b;
    logic [OP_W-1:0] op;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return op > OP_NOP;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundles the command, ALU and response signals of the issuer. The master
// modport is the issuer itself; slave is its surrounding environment.
interface alu_cmd_issuer_if #(
  parameter int TAG_W = 2
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_op_code;
  logic [3:0]       alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_zero;
  logic             rsp_illegal;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op_code,
           rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_illegal
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op_code,
           rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_illegal
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a combinational head read, so the issuer can
// drive the ALU from the head entry in the same cycle it pops it.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count_q != '0);

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time to an external combinational
// ALU and returns each registered result with its tag on a valid/ready port.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_cmd_issuer_if.master bus
);

  localparam int ENTRY_W = CMD_W + TAG_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  issuer_state_t    state_q, state_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_illegal_q, rsp_illegal_d;

  logic               fifo_push, fifo_pop, fifo_full, has_cmd;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  alu_cmd_t           in_cmd, head_cmd;
  logic [TAG_W-1:0]   head_tag;

  logic [3:0]      alu_a_c, alu_b_c;
  logic [OP_W-1:0] alu_op_c;

  assign in_cmd.a  = bus.cmd_a;
  assign in_cmd.b  = bus.cmd_b;
  assign in_cmd.op = bus.cmd_op;
  assign fifo_din  = {bus.cmd_tag, in_cmd};
  assign {head_tag, head_cmd} = fifo_dout;

  assign fifo_push = bus.cmd_valid & ~fifo_full;
  assign has_cmd   = (fifo_count != '0);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    fifo_pop      = 1'b0;
    alu_a_c       = 4'h0;
    alu_b_c       = 4'h0;
    alu_op_c      = OP_NOP;

    case (state_q)
      IDLE: begin
        if (has_cmd) state_d = ISSUE;
      end
      ISSUE: begin
        alu_a_c       = head_cmd.a;
        alu_b_c       = head_cmd.b;
        alu_op_c      = head_cmd.op;
        rsp_result_d  = bus.alu_result;
        rsp_tag_d     = head_tag;
        rsp_zero_d    = (bus.alu_result == 4'h0);
        rsp_illegal_d = op_is_illegal(head_cmd.op);
        rsp_valid_d   = 1'b1;
        fifo_pop      = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        // The next-state decision uses the registered count; a push landing
        // in this same cycle is only seen from IDLE one cycle later.
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = has_cmd ? ISSUE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 4'h0;
      rsp_tag_q     <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign bus.cmd_ready   = ~fifo_full;
  assign bus.alu_a       = alu_a_c;
  assign bus.alu_b       = alu_b_c;
  assign bus.alu_op_code = alu_op_c;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule
